// File: rtl/scratchpad_responder_if.sv
// Accelerator/host bus bundle for scratchpad_responder.
//   slave  : the scratchpad (takes requests, returns responses, status)
//   master : the requester side (accelerator + host preload agent)
// Signals:
//   mem_req_addr/mem_read_en/mem_write_en/mem_req_data : accelerator request
//   mem_resp_data/mem_resp_valid                       : read response
//   host_valid/host_ready/host_addr/host_data          : host preload writes
//   addr_err/collision_err                             : sticky error flags
//   rd_count/wr_count                                  : saturating counters
interface scratchpad_responder_if #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BANKING_FACTOR = 1,
  parameter int unsigned ADDRESS_WIDTH  = 13
);
  localparam int unsigned WORD_W = BANKING_FACTOR * DATA_WIDTH;

  logic [ADDRESS_WIDTH-1:0] mem_req_addr;
  logic                     mem_read_en;
  logic                     mem_write_en;
  logic [WORD_W-1:0]        mem_req_data;
  logic [WORD_W-1:0]        mem_resp_data;
  logic                     mem_resp_valid;
  logic                     host_valid;
  logic                     host_ready;
  logic [ADDRESS_WIDTH-1:0] host_addr;
  logic [WORD_W-1:0]        host_data;
  logic                     addr_err;
  logic                     collision_err;
  logic [31:0]              rd_count;
  logic [31:0]              wr_count;

  modport slave (
    input  mem_req_addr, mem_read_en, mem_write_en, mem_req_data,
    input  host_valid, host_addr, host_data,
    output mem_resp_data, mem_resp_valid, host_ready,
    output addr_err, collision_err, rd_count, wr_count
  );

  modport master (
    output mem_req_addr, mem_read_en, mem_write_en, mem_req_data,
    output host_valid, host_addr, host_data,
    input  mem_resp_data, mem_resp_valid, host_ready,
    input  addr_err, collision_err, rd_count, wr_count
  );
endinterface

// File: rtl/scratchpad_responder.sv
// Scratchpad memory serving an accelerator read/write port with a fixed,
// fully pipelined read latency, plus a host preload write port that yields
// to accelerator writes through a one-entry buffer.
// Ports:
//   clk  : single clock
//   rst  : asynchronous, active-high reset (storage is not cleared)
//   bus  : scratchpad_responder_if.slave (requests, responses, host port,
//          sticky error flags, saturating read/write counters)
module scratchpad_responder #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BANKING_FACTOR = 1,
  parameter int unsigned ADDRESS_WIDTH  = 13,
  parameter int unsigned DEPTH          = 8192,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  scratchpad_responder_if.slave bus
);
  localparam int unsigned WORD_W    = BANKING_FACTOR * DATA_WIDTH;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] DEPTH_EXT = 64'(DEPTH);

  typedef enum logic {
    HB_EMPTY = 1'b0,
    HB_FULL  = 1'b1
  } hb_state_t;

  function automatic logic f_in_range(input logic [ADDRESS_WIDTH-1:0] a);
    logic [63:0] ext;
    ext = 64'(a);
    return ext < DEPTH_EXT;
  endfunction

  // Storage
  logic [WORD_W-1:0]        r_mem [DEPTH];

  // Host buffer
  hb_state_t                r_hb_state;
  hb_state_t                w_hb_next;
  logic [ADDRESS_WIDTH-1:0] r_hb_addr;
  logic [WORD_W-1:0]        r_hb_data;
  logic                     w_hb_capture;
  logic                     w_hb_retire;
  logic                     w_host_direct;
  logic                     w_host_xfer;

  // Request decode
  logic                     w_req_in_range;
  logic                     w_host_in_range;
  logic                     w_hb_in_range;
  logic                     w_rd_accept;
  logic                     w_collision;
  logic [WORD_W-1:0]        w_rd_word;

  // Single memory write port
  logic                     w_mem_we;
  logic [ADDRESS_WIDTH-1:0] w_mem_waddr;
  logic [WORD_W-1:0]        w_mem_wdata;

  // Read pipeline
  logic [READ_LATENCY-1:0]  r_pipe_vld;
  logic [WORD_W-1:0]        r_pipe_dat [READ_LATENCY];

  // Status
  logic                     r_addr_err;
  logic                     r_collision_err;
  logic [31:0]              r_rd_count;
  logic [31:0]              r_wr_count;

  assign w_req_in_range  = f_in_range(bus.mem_req_addr);
  assign w_host_in_range = f_in_range(bus.host_addr);
  assign w_hb_in_range   = f_in_range(r_hb_addr);

  // A collision drops the read; the write still goes through.
  assign w_rd_accept = bus.mem_read_en & ~bus.mem_write_en;
  assign w_collision = bus.mem_read_en & bus.mem_write_en;

  // Out-of-range reads return zero but still flow through the pipeline.
  assign w_rd_word = w_req_in_range ? r_mem[bus.mem_req_addr[IDX_W-1:0]] : '0;

  assign w_host_xfer = bus.host_valid & (r_hb_state == HB_EMPTY);

  // Host buffer: a host transfer colliding with an accelerator write parks
  // here and retires in the first cycle without an accelerator write. New
  // host transfers are refused until it has retired, keeping host order.
  always_comb begin
    w_hb_next     = r_hb_state;
    w_hb_capture  = 1'b0;
    w_hb_retire   = 1'b0;
    w_host_direct = 1'b0;
    unique case (r_hb_state)
      HB_EMPTY: begin
        if (bus.host_valid) begin
          if (bus.mem_write_en) begin
            w_hb_capture = 1'b1;
            w_hb_next    = HB_FULL;
          end else begin
            w_host_direct = 1'b1;
          end
        end
      end
      HB_FULL: begin
        if (!bus.mem_write_en) begin
          w_hb_retire = 1'b1;
          w_hb_next   = HB_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hb_state <= HB_EMPTY;
      r_hb_addr  <= '0;
      r_hb_data  <= '0;
    end else begin
      r_hb_state <= w_hb_next;
      if (w_hb_capture) begin
        r_hb_addr <= bus.host_addr;
        r_hb_data <= bus.host_data;
      end
    end
  end

  // Write port arbitration: accelerator, then buffered host, then direct host.
  // The three sources are mutually exclusive by construction of the buffer.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = bus.mem_req_addr;
    w_mem_wdata = bus.mem_req_data;
    if (bus.mem_write_en) begin
      w_mem_we = w_req_in_range;
    end else if (w_hb_retire) begin
      w_mem_we    = w_hb_in_range;
      w_mem_waddr = r_hb_addr;
      w_mem_wdata = r_hb_data;
    end else if (w_host_direct) begin
      w_mem_we    = w_host_in_range;
      w_mem_waddr = bus.host_addr;
      w_mem_wdata = bus.host_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr[IDX_W-1:0]] <= w_mem_wdata;
    end
  end

  // Each stage only loads data alongside a valid, so the last stage holds
  // the previous response while no new one is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pipe_dat[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_accept;
      if (w_rd_accept) begin
        r_pipe_dat[0] <= w_rd_word;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        if (r_pipe_vld[i-1]) begin
          r_pipe_dat[i] <= r_pipe_dat[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_err      <= 1'b0;
      r_collision_err <= 1'b0;
      r_rd_count      <= '0;
      r_wr_count      <= '0;
    end else begin
      if (((bus.mem_read_en | bus.mem_write_en) & ~w_req_in_range) |
          (w_host_xfer & ~w_host_in_range)) begin
        r_addr_err <= 1'b1;
      end
      if (w_collision) begin
        r_collision_err <= 1'b1;
      end
      if (w_rd_accept && (r_rd_count != '1)) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (bus.mem_write_en && (r_wr_count != '1)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign bus.mem_resp_valid = r_pipe_vld[READ_LATENCY-1];
  assign bus.mem_resp_data  = r_pipe_dat[READ_LATENCY-1];
  assign bus.host_ready     = (r_hb_state == HB_EMPTY);
  assign bus.addr_err       = r_addr_err;
  assign bus.collision_err  = r_collision_err;
  assign bus.rd_count       = r_rd_count;
  assign bus.wr_count       = r_wr_count;
endmodule
